// File: rtl/axis_uart_rx.sv
// axis_uart_rx: oversampled UART receiver with majority-voted bit recovery,
// runtime parity / stop-bit selection, per-frame error tagging and a small
// receive FIFO drained through an AXI4-Stream master port.
// Optional feature macro: UART_RX_BREAK_DETECT_EN (break frames are flagged
// on break_det instead of being pushed as a framing-error word).
`timescale 1ns/1ps

module axis_uart_rx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic [1:0]                    m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overrun,
  output logic                          break_det
);

  localparam int unsigned Div   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DivW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned OsW   = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned WordW = DATA_BITS + 2;

  localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
  localparam logic [OsW-1:0]  OsLast  = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0]  OsS0    = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0]  OsS1    = OsW'(OVERSAMPLE / 2);
  localparam logic [OsW-1:0]  OsDec   = OsW'(OVERSAMPLE / 2 + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  // Elaboration-time parameter legality checks
  if (Div < 2) begin : g_chk_div
    $error("axis_uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be >= 2");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_chk_os
    $error("axis_uart_rx: OVERSAMPLE must be 8 or 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("axis_uart_rx: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("axis_uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StPush
  } state_e;

  state_e              r_state, w_state_d;
  logic [1:0]          r_sync;
  logic                r_rx_prev;
  logic [DivW-1:0]     r_div_cnt;
  logic [OsW-1:0]      r_os_cnt;
  logic [1:0]          r_samp;
  logic [BitW-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]          r_par_mode;
  logic                r_stop2;
  logic                r_stop_cnt;
  logic                r_frame_err;
  logic                r_parity_err;
  logic                r_wait_high;

  logic [WordW-1:0]    r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [LvlW-1:0]     r_count;

  logic                w_rx_s;
  logic                w_start;
  logic                w_tick;
  logic [OsW-1:0]      w_os_next;
  logic                w_dec;
  logic                w_maj;
  logic                w_par_on;
  logic                w_is_break;
  logic                w_push_req;
  logic                w_break;
  logic                w_pop;
  logic                w_full;
  logic                w_wr;
  logic [WordW-1:0]    w_word;

  assign w_rx_s     = r_sync[1];
  // A frame that ended in a framing error must see the line high again first
  assign w_start    = (r_state == StIdle) && !r_wait_high && r_rx_prev && !w_rx_s;
  assign w_tick     = (r_state != StIdle) && (r_div_cnt == DivLast);
  assign w_os_next  = (r_os_cnt == OsLast) ? '0 : r_os_cnt + OsW'(1);
  assign w_dec      = w_tick && (w_os_next == OsDec);
  assign w_maj      = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
  assign w_par_on   = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
  assign w_is_break = r_frame_err && (r_shift == '0);
  assign w_word     = {r_frame_err, r_parity_err, r_shift};

  // Two-stage synchronizer and previous-sample register for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_rx_prev <= w_rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state and frame-end push/break requests
  always_comb begin
    w_state_d  = r_state;
    w_push_req = 1'b0;
    w_break    = 1'b0;
    unique case (r_state)
      StIdle:   if (w_start) w_state_d = StStart;
      StStart:  if (w_dec) w_state_d = w_maj ? StIdle : StData;
      StData:   if (w_dec && (r_bit_cnt == BitLast)) w_state_d = w_par_on ? StParity : StStop;
      StParity: if (w_dec) w_state_d = StStop;
      StStop:   if (w_dec && (!r_stop2 || r_stop_cnt)) w_state_d = StPush;
      StPush: begin
        w_state_d = StIdle;
`ifdef UART_RX_BREAK_DETECT_EN
        if (w_is_break) w_break = 1'b1;
        else            w_push_req = 1'b1;
`else
        w_push_req = 1'b1;
`endif
      end
      default:  w_state_d = StIdle;
    endcase
  end

  // Tick generation, sampling and frame datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_os_cnt     <= '0;
      r_samp       <= 2'b11;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_mode   <= 2'b00;
      r_stop2      <= 1'b0;
      r_stop_cnt   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_wait_high  <= 1'b0;
    end else begin
      if (r_state == StIdle || w_tick) r_div_cnt <= '0;
      else                             r_div_cnt <= r_div_cnt + DivW'(1);

      if (r_state == StIdle) r_os_cnt <= '0;
      else if (w_tick)       r_os_cnt <= w_os_next;

      if (w_tick && (w_os_next == OsS0)) r_samp[0] <= w_rx_s;
      if (w_tick && (w_os_next == OsS1)) r_samp[1] <= w_rx_s;

      if (w_start) begin
        r_par_mode   <= parity_mode;
        r_stop2      <= stop_bits;
        r_bit_cnt    <= '0;
        r_stop_cnt   <= 1'b0;
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
        r_shift      <= '0;
      end

      if (w_dec && (r_state == StData)) begin
        r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + BitW'(1);
      end

      if (w_dec && (r_state == StParity)) begin
        r_parity_err <= ((^r_shift) ^ w_maj) != (r_par_mode == 2'b10);
      end

      if (w_dec && (r_state == StStop)) begin
        if (!w_maj) r_frame_err <= 1'b1;
        r_stop_cnt <= 1'b1;
      end

      if (r_state == StPush && r_frame_err)      r_wait_high <= 1'b1;
      else if (r_state == StIdle && w_rx_s)      r_wait_high <= 1'b0;
    end
  end

  assign w_pop  = (r_count != '0) && m_axis_tready;
  assign w_full = (r_count == LvlFull);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr   = w_push_req && (!w_full || w_pop);

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + LvlW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - LvlW'(1);
    end
  end

  assign m_axis_tdata  = r_mem[r_rd_ptr][DATA_BITS-1:0];
  assign m_axis_tuser  = r_mem[r_rd_ptr][WordW-1 -: 2];
  assign m_axis_tvalid = (r_count != '0);
  assign fifo_level    = r_count;
  assign busy          = (r_state != StIdle);
  assign overrun       = w_push_req && w_full && !w_pop;
  assign break_det     = w_break;

endmodule
